// File: rtl/int_alu_pkg.sv
// int_alu_pkg: op encodings and default width shared by the add/sub arbiter slice
package int_alu_pkg;
  localparam int DEF_ADDER_WIDTH = 32;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/int_addsub_core.sv
// int_addsub_core: combinational add/sub split into two half-width chunks with carry-select upper half
module int_addsub_core
  import int_alu_pkg::*;
#(
  parameter int W = DEF_ADDER_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] out,
  output logic         flag
);
  localparam int H = W / 2;
  logic [W-1:0] bx;
  logic [H:0]   lo, hi0, hi1, hi;
  // Subtraction is a + ~b + 1, so the low chunk's carry-in is the op bit itself
  assign bx   = (op == OP_SUB) ? ~b : b;
  assign lo   = {1'b0, a[H-1:0]} + {1'b0, bx[H-1:0]} + {{H{1'b0}}, op};
  assign hi0  = {1'b0, a[W-1:H]} + {1'b0, bx[W-1:H]};
  assign hi1  = {1'b0, a[W-1:H]} + {1'b0, bx[W-1:H]} + {{H{1'b0}}, 1'b1};
  assign hi   = lo[H] ? hi1 : hi0;
  assign out  = {hi[H-1:0], lo[H-1:0]};
  // Carry-out inverts into borrow-out for subtraction
  assign flag = hi[H] ^ op;
endmodule

// File: rtl/int_addsub_arbiter.sv
// int_addsub_arbiter: round-robin arbiter feeding one shared add/sub core into a single result register
module int_addsub_arbiter
  import int_alu_pkg::*;
#(
  parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
  parameter int NUM_REQ     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_op,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0]   req_b,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output logic [ADDER_WIDTH-1:0]           rsp_data,
  output logic                             rsp_flag
);
  localparam int W  = ADDER_WIDTH;
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] last_q, last_d, id_q, id_d, cand, idx;
  logic          cand_vld, free, xfer, valid_q, valid_d, flag_q, flag_d, core_flag;
  logic [W-1:0]  data_q, data_d, core_out;
  // Scan from farthest to nearest so the requester right after last_q wins
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    idx      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        cand_vld = 1'b1;
        cand     = idx;
      end
    end
  end
  assign free      = !valid_q || rsp_ready;
  assign xfer      = rst_n && cand_vld && free;
  assign req_ready = xfer ? (NUM_REQ'(1) << cand) : '0;
  int_addsub_core #(.W(W)) u_core (
    .a    (req_a[cand*W +: W]),
    .b    (req_b[cand*W +: W]),
    .op   (req_op[cand]),
    .out  (core_out),
    .flag (core_flag)
  );
  always_comb begin
    valid_d = xfer || (valid_q && !rsp_ready);
    data_d  = xfer ? core_out : data_q;
    flag_d  = xfer ? core_flag : flag_q;
    id_d    = xfer ? cand : id_q;
    last_d  = xfer ? cand : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      id_q    <= '0;
      last_q  <= IW'(NUM_REQ - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end
  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_flag  = flag_q;
  assign rsp_id    = id_q;
endmodule

// File: tb/tb_int_addsub_arbiter.sv
// tb_int_addsub_arbiter: directed vectors plus a cycle-by-cycle behavioural model of the arbiter
module tb_int_addsub_arbiter;
  localparam int W = 32;
  localparam int N = 4;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready, req_op;
  logic [N*W-1:0]   req_a, req_b;
  logic             rsp_valid, rsp_ready, rsp_flag;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_data;
  int               n_chk = 0, n_pass = 0;
  bit               run = 1'b0;
  always #5 clk = ~clk;
  int_addsub_arbiter #(.ADDER_WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flag(rsp_flag)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic int pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  function automatic logic [W:0] res(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    return op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  endfunction
  // Reference model: plain arithmetic result plus round-robin pick over the request vector
  logic         m_valid, m_flag;
  logic [W-1:0] m_data;
  int           m_id, m_last, g, gi;
  int           wt [N];
  logic [N-1:0] exp_rdy;
  logic [W:0]   exp_res;
  always_comb begin
    g       = pick(m_last, req_valid);
    gi      = (g < 0) ? 0 : g;
    exp_rdy = (rst_n === 1'b1 && g >= 0 && (!m_valid || rsp_ready)) ? (N'(1) << gi) : '0;
    exp_res = res(req_op[gi], req_a[gi*W +: W], req_b[gi*W +: W]);
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_flag  <= 1'b0;
      m_id    <= 0;
      m_last  <= N - 1;
      for (int i = 0; i < N; i++) wt[i] <= 0;
    end else begin
      if (exp_rdy != 0) begin
        m_valid <= 1'b1;
        m_data  <= exp_res[W-1:0];
        m_flag  <= exp_res[W];
        m_id    <= gi;
        m_last  <= gi;
      end else if (rsp_ready) m_valid <= 1'b0;
      for (int i = 0; i < N; i++)
        wt[i] <= (!req_valid[i] || (exp_rdy != 0 && i == gi)) ? 0 : (exp_rdy != 0 ? wt[i] + 1 : wt[i]);
    end
  end
  always @(negedge clk) begin
    if (run) begin
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, m_valid);
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_flag", rsp_flag, m_flag);
      chk("rsp_id", rsp_id, m_id);
      for (int i = 0; i < N; i++) chk("starve", wt[i] <= N - 1, 1);
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set(input int i, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[i] = op;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask
  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return $urandom;
    endcase
  endfunction
  logic [N-1:0] gnt;
  initial begin
    rst_n = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_ready", req_ready, 0);
    req_valid = '0;
    repeat (2) step;
    rst_n = 1'b1;
    run = 1'b1;
    set(0, 1'b0, 32'h0000FFFF, 32'h1);
    req_valid = 4'b0001;
    #1 chk("first_ready", req_ready, 4'b0001);
    step;
    chk("first_valid", rsp_valid, 1);
    chk("first_id", rsp_id, 0);
    chk("first_data", rsp_data, 32'h00010000);
    chk("first_flag", rsp_flag, 0);
    set(1, 1'b0, 32'hFFFFFFFF, 32'h1);
    req_valid = 4'b0010;
    step;
    chk("addwrap_data", rsp_data, 0);
    chk("addwrap_flag", rsp_flag, 1);
    chk("addwrap_id", rsp_id, 1);
    set(2, 1'b1, 32'h00010000, 32'h1);
    req_valid = 4'b0100;
    step;
    chk("sub_data", rsp_data, 32'h0000FFFF);
    chk("sub_flag", rsp_flag, 0);
    set(3, 1'b1, 32'h0, 32'h1);
    req_valid = 4'b1000;
    step;
    chk("subwrap_data", rsp_data, 32'hFFFFFFFF);
    chk("subwrap_flag", rsp_flag, 1);
    chk("subwrap_id", rsp_id, 3);
    for (int i = 0; i < N; i++) set(i, 1'b0, W'(i * 256), 32'd7);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step;
      chk("rr_valid", rsp_valid, 1);
      chk("rr_id", rsp_id, k % N);
      chk("rr_data", rsp_data, (k % N) * 256 + 7);
    end
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("stall_ready", req_ready, 0);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_id", rsp_id, 0);
      chk("stall_data", rsp_data, 7);
    end
    rsp_ready = 1'b1;
    #1 chk("drain_ready", req_ready, 4'b0010);
    step;
    chk("drain_valid", rsp_valid, 1);
    chk("drain_id", rsp_id, 1);
    chk("drain_data", rsp_data, 32'h107);
    rsp_ready = 1'b0;
    step;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_ready", req_ready, 0);
    #2 rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1 chk("post_rst_ready", req_ready, 4'b0001);
    step;
    chk("post_rst_id", rsp_id, 0);
    chk("post_rst_data", rsp_data, 7);
    // Unserved requests stay asserted so fairness is exercised under contention
    for (int c = 0; c < 3000; c++) begin
      gnt = req_ready;
      req_valid = (req_valid & ~gnt) | (N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
      req_op = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = rnd_val();
        req_b[i*W +: W] = rnd_val();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step;
    end
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
